// File: rtl/enc_quad_multi.sv
// Multi-channel quadrature decoder with sampled glitch filter,
// x1/x2/x4 counting, illegal-transition detection and wrap/clamp position.
module enc_quad_multi #(
    parameter int N_CH       = 2,
    parameter int POS_W      = 16,
    parameter int SAMPLE_DIV = 100,
    parameter int FILT_LEN   = 3,
    parameter int SATURATE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         enc_a,
    input  logic [N_CH-1:0]         enc_b,
    input  logic [1:0]              mode,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH-1:0]         step_p,
    output logic [N_CH-1:0]         dir,
    output logic [N_CH*POS_W-1:0]   pos,
    output logic [N_CH-1:0]         err_p,
    output logic [N_CH-1:0]         err_flag
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [3:0] F_LAST = 4'(FILT_LEN - 1);
    localparam logic [3:0] F_FULL = 4'(FILT_LEN);
    localparam logic [POS_W-1:0] P_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] P_MIN = {1'b1, {(POS_W-1){1'b0}}};

    // Lines [N_CH-1:0] are A, lines [2*N_CH-1:N_CH] are B.
    logic [2*N_CH-1:0] sy1, sy2, filt, prev;
    logic [PW-1:0] presc;
    logic [3:0] wcnt;
    logic tick, warm, tick_d;

    assign tick = (presc == P_LAST);
    assign warm = (wcnt != F_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sy1 <= '1;
            sy2 <= '1;
        end else begin
            sy1 <= {enc_b, enc_a};
            sy2 <= sy1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc  <= '0;
            wcnt   <= '0;
            tick_d <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            tick_d <= tick & ~warm;
            if (tick && warm) wcnt <= wcnt + 1'b1;
        end
    end

    for (genvar l = 0; l < 2*N_CH; l++) begin : g_line
        logic [3:0] agree;
        logic f, pv;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                agree <= '0;
                f     <= 1'b1;
                pv    <= 1'b1;
            end else if (tick) begin
                if (warm) begin
                    f     <= sy2[l];
                    pv    <= sy2[l];
                    agree <= '0;
                end else if (sy2[l] != f) begin
                    if (agree == F_LAST) begin
                        f     <= sy2[l];
                        agree <= '0;
                    end else begin
                        agree <= agree + 1'b1;
                    end
                end else begin
                    agree <= '0;
                end
            end else if (tick_d) begin
                pv <= f;
            end
        end

        assign filt[l] = f;
        assign prev[l] = pv;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [1:0] cur, prv, ci, pi, df;
        logic fwd, bad, mov, cnt, err;
        logic sp, dr, ep, ef;
        logic [POS_W-1:0] p, p_nx;

        assign cur = {filt[k], filt[N_CH+k]};
        assign prv = {prev[k], prev[N_CH+k]};
        // Gray state to ring index: 00,01,11,10 -> 0,1,2,3
        assign ci  = {cur[1], cur[1] ^ cur[0]};
        assign pi  = {prv[1], prv[1] ^ prv[0]};
        assign df  = ci - pi;
        assign fwd = (df == 2'd1);
        assign bad = (df == 2'd2);
        assign mov = df[0];

        assign cnt = tick_d & mov &
                     (mode[1] | (mode[0] ? (prv[1] ^ cur[1])
                                         : (~prv[1] & cur[1])));
        assign err = tick_d & bad;

        always_comb begin
            p_nx = p;
            if (fwd) begin
                if (!(SATURATE != 0 && p == P_MAX)) p_nx = p + 1'b1;
            end else begin
                if (!(SATURATE != 0 && p == P_MIN)) p_nx = p - 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sp <= 1'b0;
                dr <= 1'b0;
                ep <= 1'b0;
                ef <= 1'b0;
                p  <= '0;
            end else begin
                sp <= cnt;
                ep <= err;
                if (clr[k]) begin
                    p  <= '0;
                    ef <= 1'b0;
                end else begin
                    if (cnt) begin
                        p  <= p_nx;
                        dr <= fwd;
                    end
                    if (err) ef <= 1'b1;
                end
            end
        end

        assign step_p[k]             = sp;
        assign dir[k]                = dr;
        assign err_p[k]              = ep;
        assign err_flag[k]           = ef;
        assign pos[k*POS_W +: POS_W] = p;
    end

endmodule
